// File: rtl/normalizer_if.sv
// normalizer_if: handshake bundle between a producer/consumer and the
// normalizer.
//
// Input side:  in_valid, in_ready, A, Mode
// Output side: out_valid, out_ready, Result, Count, Zero
//
// Modports:
//   slave  - the normalizer (accepts operands, offers results)
//   master - the client (offers operands, accepts results)
interface normalizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic                  Mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic [CNT_WIDTH-1:0]  Count;
  logic                  Zero;

  modport slave (
    input  in_valid, A, Mode, out_ready,
    output in_ready, out_valid, Result, Count, Zero
  );

  modport master (
    output in_valid, A, Mode, out_ready,
    input  in_ready, out_valid, Result, Count, Zero
  );
endinterface

// File: rtl/normalizer.sv
// normalizer: multi-cycle normalization unit (CLZ / CLS).
//
// The unit accepts operand A and Mode. It finds the left shift that
// normalizes A and returns the shifted value (Result) and the shift
// amount (Count).
//   Mode 0: Count is the number of leading zeros.
//           A == 0 gives Count = 32.
//   Mode 1: Count is the number of redundant sign bits.
//           The maximum is 31.
// Zero flags an all-zero operand.
//
// The search is a binary one, one step per clock with k = 16, 8, 4, 2, 1.
// A result appears five edges after the accepting edge.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - normalizer_if.slave
//           (in_valid/in_ready/A/Mode, out_valid/out_ready/Result/Count/Zero)
module normalizer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  normalizer_if.slave  bus
);

  localparam int SW = CNT_WIDTH - 1;
  localparam logic [SW-1:0] STEP0 = SW'(DATA_WIDTH / 2);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q,  work_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  zero_q,  zero_d;
  logic                  mode_q,  mode_d;
  logic [SW-1:0]         step_q,  step_d;
  logic                  hit;

  // Top k bits of w are all zero.
  function automatic logic top_zero(input logic [DATA_WIDTH-1:0] w,
                                    input logic [SW-1:0]         k);
    logic [DATA_WIDTH-1:0] sh;
    sh = w >> (DATA_WIDTH - int'(k));
    return (sh == '0);
  endfunction

  // Top k+1 bits of w are all equal. The arithmetic shift leaves those
  // bits at the bottom and replicates the sign above them, so they are
  // equal exactly when the whole word is all zeros or all ones.
  function automatic logic top_sign(input logic [DATA_WIDTH-1:0] w,
                                    input logic [SW-1:0]         k);
    logic signed [DATA_WIDTH-1:0] sh;
    sh = $signed(w) >>> (DATA_WIDTH - 1 - int'(k));
    return (sh == '0) || (&sh);
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mode_d  = mode_q;
    step_d  = step_q;
    hit     = mode_q ? top_sign(work_q, step_q) : top_zero(work_q, step_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.A;
          mode_d  = bus.Mode;
          cnt_d   = '0;
          zero_d  = (bus.A == '0);
          step_d  = STEP0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          work_d = work_q << step_q;
          cnt_d  = cnt_q + CNT_WIDTH'(step_q);
        end
        step_d = step_q >> 1;
        if (step_q == SW'(1)) begin
          state_d = DONE;
          step_d  = STEP0;
          // The steps sum to 31 at most. An all-zero unsigned operand
          // needs the full width.
          if (!mode_q && zero_q) begin
            cnt_d = CNT_WIDTH'(DATA_WIDTH);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mode_q  <= 1'b0;
      step_q  <= STEP0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  // in_ready is gated by rst_n so that it stays low for the whole reset
  // assertion, even though the state register already reads IDLE.
  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.Result    = work_q;
  assign bus.Count     = cnt_q;
  assign bus.Zero      = zero_q;

endmodule

// File: doc/normalizer.md
Name: normalizer

Overview:
Multi-cycle normalization unit, the inverse of the barrel shifter. The shifter takes a value and a shift amount and produces a shifted value. This block takes a value and finds the left-shift amount that normalizes it. It reports both the normalized value and that shift count. It uses a valid/ready handshake on input and output and sits beside the ALU/shifter for CLZ/CLS-style operations and software-float support.

Parameters:
DATA_WIDTH, 32, operand width; fixed power of two, only 32 is supported.
CNT_WIDTH, 6, width of Count; equals log2(DATA_WIDTH)+1 so the unsigned all-zero count of 32 fits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  A/Mode valid
in_ready  output  1  block can accept an operand
A  input  DATA_WIDTH  operand
Mode  input  1  0 = unsigned (count leading zeros); 1 = signed (count redundant sign bits)
out_valid  output  1  Result/Count/Zero valid
out_ready  input  1  consumer accepts the result
Result  output  DATA_WIDTH  normalized value, equal to A << Count (low bits zero-filled)
Count  output  CNT_WIDTH  left-shift amount applied
Zero  output  1  A was all zeros

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=0 while asserted, out_valid=0, Result=0, Count=0, Zero=0, step=16. After release, in_ready=1 (IDLE).
- Reset mid-SCAN or in DONE: the operation is abandoned and out_valid drops immediately. No result is produced.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready at edge E0, latch A into the work register and Mode. Set Count=0, Zero=(A==0), step=16, then go to SCAN.
  - SCAN: one step per edge with k = 16, 8, 4, 2, 1 on edges E1..E5. in_ready=0, out_valid=0.
    - Mode 0: if the top k bits of the work register are all 0, shift it left by k and add k to Count.
    - Mode 1: if the top k+1 bits are all equal, shift it left by k and add k to Count.
    - At E5, go to DONE. If Mode==0 and Zero==1, Count is forced to 32 at E5 (the steps alone reach 31).
  - DONE: out_valid=1, in_ready=0. Result/Count/Zero are held stable while out_ready=0. On out_valid && out_ready, go to IDLE.
- in_ready is asserted only in IDLE. There is no accept in the same cycle as the output handshake; minimum initiation interval is 7 cycles.
- Latency: out_valid is high from the edge after E5, i.e. the 5th edge after the accepting edge E0.
- in_valid and A are ignored outside IDLE. Changes to A after the accepting edge do not affect the result.
- Result/Count/Zero are only meaningful while out_valid=1. During SCAN they show the work registers.
- Count width rules:
  - Mode 0: Count ranges 0..32; A=0 gives Count=32, Result=0.
  - Mode 1: Count ranges 0..31. A=0 and A=0xFFFFFFFF both give Count=31; Result = A<<31.
- Zero depends only on A and is independent of Mode.
- Count additions never overflow CNT_WIDTH; the step sum is at most 31.

Test Plan:
- Mode0, A=0x00001000 -> after 5 cycles out_valid=1, Result=0x80000000, Count=19, Zero=0. Mode0, A=0x80000001 -> Result=0x80000001, Count=0.
- Mode0, A=0x00000000 -> Result=0, Count=32, Zero=1. Mode1, A=0 -> Count=31, Zero=1, Result=0.
- Mode1, A=0xFFFFFFF0 -> Result=0x80000000, Count=27. Mode1, A=0x00000001 -> Result=0x40000000, Count=30. Mode1, A=0xFFFFFFFF -> Result=0x80000000, Count=31, Zero=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with A=0x1 -> outputs stay constant and in_ready stays 0. Then out_ready=1 -> IDLE, in_ready=1, and the new operand is accepted the cycle after.
- Reset: pull rst_n low asynchronously on the 3rd SCAN cycle -> out_valid=0 and Count=0 at once. After release, in_ready=1, and a fresh A=0x00000100 (Mode0) returns Count=23, Result=0x80000000.
- Back-to-back: 20 random operands in both modes with random in_valid/out_ready gaps. Compare each result against a reference model computing Count and A<<Count. Require no dropped or duplicated transactions.
